// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the buffered UART MMIO bridge: status bit
// positions, register offsets, default queue geometry and a small
// address decode helper used by the CPU-side load/store logic.
package uart_bridge_pkg;

    localparam int DEFAULT_DEPTH  = 16;
    localparam int DEFAULT_DWIDTH = 8;

    localparam int STAT_TX_READY_BIT = 0;
    localparam int STAT_RX_VALID_BIT = 1;
    localparam int STAT_OVERFLOW_BIT = 2;

    localparam logic [3:0] UART_STATUS_OFFSET  = 4'h0;
    localparam logic [3:0] UART_RX_DATA_OFFSET = 4'h4;
    localparam logic [3:0] UART_TX_DATA_OFFSET = 4'h8;

    typedef enum logic [1:0] {
        UART_REG_STATUS,
        UART_REG_RX_DATA,
        UART_REG_TX_DATA,
        UART_REG_NONE
    } uart_reg_e;

    // Map a word offset inside the UART window to the register it selects.
    function automatic uart_reg_e decode_offset(input logic [3:0] offset);
        uart_reg_e sel;
        case (offset)
            UART_STATUS_OFFSET:  sel = UART_REG_STATUS;
            UART_RX_DATA_OFFSET: sel = UART_REG_RX_DATA;
            UART_TX_DATA_OFFSET: sel = UART_REG_TX_DATA;
            default:             sel = UART_REG_NONE;
        endcase
        return sel;
    endfunction

    // Assemble the status register bits from the individual flags.
    function automatic logic [2:0] pack_status(input logic tx_ready,
                                               input logic rx_valid,
                                               input logic overflow);
        logic [2:0] s;
        s = '0;
        s[STAT_TX_READY_BIT] = tx_ready;
        s[STAT_RX_VALID_BIT] = rx_valid;
        s[STAT_OVERFLOW_BIT] = overflow;
        return s;
    endfunction

endpackage

// File: rtl/uart_fifo_bridge_sync_fifo.sv
// sync_fifo: single-clock circular-buffer queue with first-word
// fall-through head, registered occupancy count and full/empty derived
// only from that count. A push is taken when not full, or when a pop
// frees a slot in the same cycle.
module sync_fifo
    import uart_bridge_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int DWIDTH = DEFAULT_DWIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_req,
    input  logic [DWIDTH-1:0]        push_data,
    input  logic                     pop_req,
    output logic [DWIDTH-1:0]        head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     cnt;
    logic              do_push;
    logic              do_pop;

    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign count     = cnt;
    assign head_data = mem[rd_ptr];
    assign do_pop    = pop_req && !empty;
    assign do_push   = push_req && (!full || do_pop);

    // Storage array: written on accepted pushes, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; the count tracks net occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: buffers CPU stores toward the UART transmitter and
// UART received bytes toward CPU loads, and keeps a sticky flag for
// stores dropped at a full TX queue.
// Build option UART_RX_FIFO_EN: when defined the RX side gets its own
// queue; otherwise the RX path is a direct wire-through.
module uart_fifo_bridge
    import uart_bridge_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int DWIDTH = DEFAULT_DWIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DWIDTH-1:0]        cpu_tx_data,
    input  logic                     cpu_tx_valid,
    output logic                     cpu_tx_ready,
    output logic [DWIDTH-1:0]        uart_tx_data,
    output logic                     uart_tx_valid,
    input  logic                     uart_tx_ready,
    input  logic [DWIDTH-1:0]        uart_rx_data,
    input  logic                     uart_rx_valid,
    output logic                     uart_rx_ready,
    output logic [DWIDTH-1:0]        cpu_rx_data,
    output logic                     cpu_rx_valid,
    input  logic                     cpu_rx_pop,
    output logic [$clog2(DEPTH):0]   tx_count,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic                     tx_overflow,
    input  logic                     ovf_clr
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic tx_full;
    logic tx_empty;
    logic tx_pop;
    logic tx_drop;
    logic ovf_q;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DWIDTH (DWIDTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_req  (cpu_tx_valid),
        .push_data (cpu_tx_data),
        .pop_req   (uart_tx_ready),
        .head_data (uart_tx_data),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    assign cpu_tx_ready  = !tx_full;
    assign uart_tx_valid = !tx_empty;
    assign tx_pop        = uart_tx_valid && uart_tx_ready;
    assign tx_drop       = cpu_tx_valid && tx_full && !tx_pop;
    assign tx_overflow   = ovf_q;

    // Sticky overflow: a new drop takes priority over a clear request.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (tx_drop) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_EN
    logic rx_full;
    logic rx_empty;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DWIDTH (DWIDTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_req  (uart_rx_valid && uart_rx_ready),
        .push_data (uart_rx_data),
        .pop_req   (cpu_rx_pop),
        .head_data (cpu_rx_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    assign uart_rx_ready = !rx_full;
    assign cpu_rx_valid  = !rx_empty;
`else
    assign cpu_rx_data   = uart_rx_data;
    assign cpu_rx_valid  = uart_rx_valid;
    assign uart_rx_ready = cpu_rx_pop;
    assign rx_count      = {{(CW-1){1'b0}}, uart_rx_valid};
`endif

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Testbench for uart_fifo_bridge. Directed stimulus pushes expected bytes
// into per-direction queues; a negedge monitor pops and compares them
// whenever a handshake completes on the DUT outputs.
module tb_uart_fifo_bridge;

    localparam int DEPTH  = 16;
    localparam int DWIDTH = 8;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic [DWIDTH-1:0] cpu_tx_data;
    logic              cpu_tx_valid;
    logic              cpu_tx_ready;
    logic [DWIDTH-1:0] uart_tx_data;
    logic              uart_tx_valid;
    logic              uart_tx_ready;
    logic [DWIDTH-1:0] uart_rx_data;
    logic              uart_rx_valid;
    logic              uart_rx_ready;
    logic [DWIDTH-1:0] cpu_rx_data;
    logic              cpu_rx_valid;
    logic              cpu_rx_pop;
    logic [CW-1:0]     tx_count;
    logic [CW-1:0]     rx_count;
    logic              tx_overflow;
    logic              ovf_clr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DWIDTH-1:0] tx_exp[$];
    logic [DWIDTH-1:0] rx_exp[$];
    logic [DWIDTH-1:0] mon_exp;

    uart_fifo_bridge #(
        .DEPTH  (DEPTH),
        .DWIDTH (DWIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_tx_data   (cpu_tx_data),
        .cpu_tx_valid  (cpu_tx_valid),
        .cpu_tx_ready  (cpu_tx_ready),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .cpu_rx_data   (cpu_rx_data),
        .cpu_rx_valid  (cpu_rx_valid),
        .cpu_rx_pop    (cpu_rx_pop),
        .tx_count      (tx_count),
        .rx_count      (rx_count),
        .tx_overflow   (tx_overflow),
        .ovf_clr       (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: compare each completed handshake with the queue head.
    always @(negedge clk) begin
        if (!rst && uart_tx_valid && uart_tx_ready) begin
            n_cmp++;
            if (tx_exp.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL tx_unexpected: got %02h, expected no byte", uart_tx_data);
            end else begin
                mon_exp = tx_exp.pop_front();
                if (uart_tx_data !== mon_exp) begin
                    n_bad++;
                    $display("[TB] FAIL tx_byte: got %02h, expected %02h", uart_tx_data, mon_exp);
                end
            end
        end
        if (!rst && cpu_rx_valid && cpu_rx_pop) begin
            n_cmp++;
            if (rx_exp.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL rx_unexpected: got %02h, expected no byte", cpu_rx_data);
            end else begin
                mon_exp = rx_exp.pop_front();
                if (cpu_rx_data !== mon_exp) begin
                    n_bad++;
                    $display("[TB] FAIL rx_byte: got %02h, expected %02h", cpu_rx_data, mon_exp);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Hold one set of inputs across exactly one rising edge, then go idle.
    task automatic applyStimulus(input logic txv, input logic [7:0] txd,
                                 input logic txr, input logic rxv,
                                 input logic [7:0] rxd, input logic rxp,
                                 input logic clr);
        cpu_tx_valid  = txv;
        cpu_tx_data   = txd;
        uart_tx_ready = txr;
        uart_rx_valid = rxv;
        uart_rx_data  = rxd;
        cpu_rx_pop    = rxp;
        ovf_clr       = clr;
        @(posedge clk);
        #1;
        cpu_tx_valid  = 1'b0;
        uart_tx_ready = 1'b0;
        uart_rx_valid = 1'b0;
        cpu_rx_pop    = 1'b0;
        ovf_clr       = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        cpu_tx_valid  = 1'b0;
        cpu_tx_data   = '0;
        uart_tx_ready = 1'b0;
        uart_rx_valid = 1'b0;
        uart_rx_data  = '0;
        cpu_rx_pop    = 1'b0;
        ovf_clr       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        checkOutput("rst_tx_count", 32'(tx_count), 0);
        checkOutput("rst_rx_count", 32'(rx_count), 0);
        checkOutput("rst_tx_valid", 32'(uart_tx_valid), 0);
        checkOutput("rst_rx_valid", 32'(cpu_rx_valid), 0);
        checkOutput("rst_tx_ready", 32'(cpu_tx_ready), 1);
        checkOutput("rst_overflow", 32'(tx_overflow), 0);
`ifdef UART_RX_FIFO_EN
        checkOutput("rst_rx_ready", 32'(uart_rx_ready), 1);
`else
        checkOutput("rst_rx_ready", 32'(uart_rx_ready), 0);
`endif

        // Three stores held back, then drained in order
        tx_exp.push_back(8'h41);
        applyStimulus(1, 8'h41, 0, 0, 8'h00, 0, 0);
        checkOutput("lat1_tx_valid", 32'(uart_tx_valid), 1);
        checkOutput("lat1_tx_data", 32'(uart_tx_data), 32'h41);
        tx_exp.push_back(8'h42);
        applyStimulus(1, 8'h42, 0, 0, 8'h00, 0, 0);
        tx_exp.push_back(8'h43);
        applyStimulus(1, 8'h43, 0, 0, 8'h00, 0, 0);
        checkOutput("three_tx_count", 32'(tx_count), 3);
        checkOutput("three_tx_head", 32'(uart_tx_data), 32'h41);
        repeat (3) applyStimulus(0, 8'h00, 1, 0, 8'h00, 0, 0);
        checkOutput("drain_tx_count", 32'(tx_count), 0);
        checkOutput("drain_tx_valid", 32'(uart_tx_valid), 0);

        // Fill to DEPTH, then overflow and the sticky flag
        for (int i = 0; i < DEPTH; i++) begin
            tx_exp.push_back(8'(8'h10 + i));
            applyStimulus(1, 8'(8'h10 + i), 0, 0, 8'h00, 0, 0);
        end
        checkOutput("full_tx_ready", 32'(cpu_tx_ready), 0);
        checkOutput("full_tx_count", 32'(tx_count), DEPTH);
        checkOutput("pre_drop_ovf", 32'(tx_overflow), 0);
        applyStimulus(1, 8'hFF, 0, 0, 8'h00, 0, 0);
        checkOutput("drop_ovf", 32'(tx_overflow), 1);
        checkOutput("drop_tx_count", 32'(tx_count), DEPTH);
        applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
        checkOutput("clr_ovf", 32'(tx_overflow), 0);
        applyStimulus(1, 8'hEE, 0, 0, 8'h00, 0, 1);
        checkOutput("set_wins_ovf", 32'(tx_overflow), 1);
        applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
        checkOutput("clr2_ovf", 32'(tx_overflow), 0);

        // Store into a full queue while it drains is accepted
        tx_exp.push_back(8'h55);
        applyStimulus(1, 8'h55, 1, 0, 8'h00, 0, 0);
        checkOutput("full_pushpop_count", 32'(tx_count), DEPTH);
        checkOutput("full_pushpop_ovf", 32'(tx_overflow), 0);
        repeat (DEPTH) applyStimulus(0, 8'h00, 1, 0, 8'h00, 0, 0);
        checkOutput("drain2_tx_count", 32'(tx_count), 0);

        // Streaming push/pop to carry the pointers past the wrap
        for (int i = 0; i < 20; i++) begin
            tx_exp.push_back(8'(8'h80 + i));
            applyStimulus(1, 8'(8'h80 + i), 1, 0, 8'h00, 0, 0);
        end
        checkOutput("stream_tx_count", 32'(tx_count), 1);
        applyStimulus(0, 8'h00, 1, 0, 8'h00, 0, 0);
        checkOutput("stream_drain_count", 32'(tx_count), 0);

`ifdef UART_RX_FIFO_EN
        // RX queue fill, backpressure, single pop and full drain
        for (int i = 0; i < DEPTH; i++) begin
            rx_exp.push_back(8'(8'hA0 + i));
            applyStimulus(0, 8'h00, 0, 1, 8'(8'hA0 + i), 0, 0);
        end
        checkOutput("rx_full_ready", 32'(uart_rx_ready), 0);
        checkOutput("rx_full_count", 32'(rx_count), DEPTH);
        applyStimulus(0, 8'h00, 0, 1, 8'hB0, 0, 0);
        checkOutput("rx_held_count", 32'(rx_count), DEPTH);
        applyStimulus(0, 8'h00, 0, 1, 8'hB0, 1, 0);
        checkOutput("rx_pop_count", 32'(rx_count), DEPTH - 1);
        checkOutput("rx_pop_ready", 32'(uart_rx_ready), 1);
        rx_exp.push_back(8'hB0);
        applyStimulus(0, 8'h00, 0, 1, 8'hB0, 0, 0);
        checkOutput("rx_refill_count", 32'(rx_count), DEPTH);
        repeat (DEPTH) applyStimulus(0, 8'h00, 0, 0, 8'h00, 1, 0);
        checkOutput("rx_drain_count", 32'(rx_count), 0);
        applyStimulus(0, 8'h00, 0, 0, 8'h00, 1, 0);
        checkOutput("rx_empty_pop_count", 32'(rx_count), 0);
        checkOutput("rx_empty_pop_valid", 32'(cpu_rx_valid), 0);
`else
        // Wire-through RX path observed within the cycle
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h7E;
        cpu_rx_pop    = 1'b0;
        #2;
        checkOutput("pt_rx_data", 32'(cpu_rx_data), 32'h7E);
        checkOutput("pt_rx_valid", 32'(cpu_rx_valid), 1);
        checkOutput("pt_rx_ready_lo", 32'(uart_rx_ready), 0);
        checkOutput("pt_rx_count", 32'(rx_count), 1);
        rx_exp.push_back(8'h7E);
        cpu_rx_pop = 1'b1;
        #1;
        checkOutput("pt_rx_ready_hi", 32'(uart_rx_ready), 1);
        @(posedge clk);
        #1;
        uart_rx_valid = 1'b0;
        cpu_rx_pop    = 1'b0;
        #1;
        checkOutput("pt_rx_count_idle", 32'(rx_count), 0);
`endif

        // Reset with bytes queued discards them
        for (int i = 0; i < 5; i++) begin
`ifdef UART_RX_FIFO_EN
            applyStimulus(1, 8'(8'h60 + i), 0, 1, 8'(8'hC0 + i), 0, 0);
`else
            applyStimulus(1, 8'(8'h60 + i), 0, 0, 8'h00, 0, 0);
`endif
        end
        checkOutput("pre_rst_tx_count", 32'(tx_count), 5);
`ifdef UART_RX_FIFO_EN
        checkOutput("pre_rst_rx_count", 32'(rx_count), 5);
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("mid_rst_tx_count", 32'(tx_count), 0);
        checkOutput("mid_rst_rx_count", 32'(rx_count), 0);
        checkOutput("mid_rst_tx_valid", 32'(uart_tx_valid), 0);
        checkOutput("mid_rst_rx_valid", 32'(cpu_rx_valid), 0);
        checkOutput("mid_rst_tx_ready", 32'(cpu_tx_ready), 1);

        // Every expected byte must have been seen by the monitor
        checkOutput("tx_leftover", 32'(tx_exp.size()), 0);
        checkOutput("rx_leftover", 32'(rx_exp.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
